mesi_isc_tb_ins_gen: RTL and testbench

MESI_ISC_TB_INS_GEN -- requirements
Module: mesi_isc_tb_ins_gen

---
 rtl/mesi_isc_tb_ins_gen.sv | 90 +++++++++
 tb/tb_mesi_isc_tb_ins_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_tb_ins_gen.sv
// mesi_isc_tb_ins_gen: LFSR-driven WR/RD/NOP instruction generator for a CPU model, with ack handshake and timeout flag
module mesi_isc_tb_ins_gen #(
  parameter int          CPU_ID      = 0,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_INS     = 1000,
  parameter int          ADDR_MAX    = 9,
  parameter int          ACK_TIMEOUT = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [3:0]  tb_ins_o,
  output logic [3:0]  tb_ins_addr_o,
  input  logic        tb_ins_ack_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] ins_cnt_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] rd_cnt_o
);
  localparam logic [15:0] SEED_X = SEED ^ 16'(CPU_ID);
  localparam logic [15:0] SEED_I = SEED_X == 16'h0000 ? 16'h0001 : SEED_X;
  localparam logic [3:0] NOP = 4'd0, WR = 4'd1, RD = 4'd2;
  typedef enum logic [2:0] {IDLE, GEN, ISSUE, GAP, DONE} state_t;
  state_t state;
  logic [15:0] lfsr, lfsr_nxt, wait_cnt;
  logic [3:0] op, addr, raw;
  logic [1:0] gap_cnt;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction
  always_comb begin
    lfsr_nxt = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
    raw = lfsr[7:4];
    op = lfsr[1:0] == 2'd0 ? NOP : lfsr[1:0] == 2'd1 ? WR : RD;
    addr = raw > 4'(ADDR_MAX) ? raw - 4'(ADDR_MAX + 1) : raw;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lfsr <= SEED_I;
      tb_ins_o <= NOP;
      tb_ins_addr_o <= '0;
      gap_cnt <= '0;
      wait_cnt <= '0;
      done_o <= 1'b0;
      timeout_o <= 1'b0;
      ins_cnt_o <= '0;
      wr_cnt_o <= '0;
      rd_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: if (en_i && ins_cnt_o < 16'(NUM_INS)) state <= GEN;
        GEN: begin
          lfsr <= lfsr_nxt;
          tb_ins_o <= op;
          tb_ins_addr_o <= addr;
          gap_cnt <= lfsr[9:8];
          wait_cnt <= '0;
          if (op == NOP) ins_cnt_o <= sat_inc(ins_cnt_o);
          state <= op == NOP ? GAP : ISSUE;
        end
        ISSUE: begin
          if (tb_ins_ack_i) begin
            tb_ins_o <= NOP;
            ins_cnt_o <= sat_inc(ins_cnt_o);
            if (tb_ins_o == WR) wr_cnt_o <= sat_inc(wr_cnt_o);
            else rd_cnt_o <= sat_inc(rd_cnt_o);
            state <= GAP;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (sat_inc(wait_cnt) >= 16'(ACK_TIMEOUT)) timeout_o <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
          else if (ins_cnt_o == 16'(NUM_INS)) begin
            state <= DONE;
            done_o <= 1'b1;
          end else state <= en_i ? GEN : IDLE;
        end
        DONE: begin
          done_o <= 1'b1;
          tb_ins_o <= NOP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_isc_tb_ins_gen.sv
// tb_mesi_isc_tb_ins_gen: directed checks of the instruction generator against hand-computed and LFSR-model values
module tb_mesi_isc_tb_ins_gen;
  logic clk = 0, rst = 0, en = 0, man_ack = 0, auto_ack = 0, auto_v = 0, ack2 = 0;
  logic ack;
  logic [3:0] tb_ins_o, tb_ins_addr_o, op2, addr2;
  logic done_o, timeout_o, done2, to2;
  logic [15:0] ins_cnt_o, wr_cnt_o, rd_cnt_o, ic2, wc2, rc2;
  logic [3:0] prev_op = 0;
  logic [15:0] prev_ins = 0, prev_wr = 0, prev_rd = 0;
  logic got2 = 0;
  logic [7:0] cap2 = 0;
  logic [7:0] ev_q[$];
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] op; logic [3:0] addr;} vec_t;
  vec_t tbl[6];

  assign ack = auto_ack ? auto_v : man_ack;
  always #5 clk = ~clk;

  mesi_isc_tb_ins_gen #(.NUM_INS(20)) dut (
    .clk(clk), .rst(rst), .en_i(en), .tb_ins_o(tb_ins_o), .tb_ins_addr_o(tb_ins_addr_o),
    .tb_ins_ack_i(ack), .done_o(done_o), .timeout_o(timeout_o),
    .ins_cnt_o(ins_cnt_o), .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o));

  mesi_isc_tb_ins_gen #(.CPU_ID(3), .SEED(16'h0003), .NUM_INS(20)) dut2 (
    .clk(clk), .rst(rst), .en_i(en), .tb_ins_o(op2), .tb_ins_addr_o(addr2),
    .tb_ins_ack_i(ack2), .done_o(done2), .timeout_o(to2),
    .ins_cnt_o(ic2), .wr_cnt_o(wc2), .rd_cnt_o(rc2));

  // Event monitor: a WR/RD shows up on tb_ins_o; a NOP only as a count bump without wr/rd change.
  always @(negedge clk) begin
    auto_v = (tb_ins_o != 0) && !auto_v;
    ack2 = (op2 != 0) && !ack2;
    if (rst && tb_ins_o != 0 && prev_op == 0) ev_q.push_back({tb_ins_o, tb_ins_addr_o});
    else if (rst && ins_cnt_o != prev_ins && wr_cnt_o == prev_wr && rd_cnt_o == prev_rd)
      ev_q.push_back({4'd0, tb_ins_addr_o});
    prev_op = tb_ins_o;
    prev_ins = ins_cnt_o;
    prev_wr = wr_cnt_o;
    prev_rd = rd_cnt_o;
    if (!rst) got2 = 0;
    else if (!got2 && op2 != 0) begin
      got2 = 1;
      cap2 = {op2, addr2};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction

  function automatic logic [7:0] dec(input logic [15:0] v);
    logic [3:0] o, a;
    o = v[1:0] == 2'd0 ? 4'd0 : v[1:0] == 2'd1 ? 4'd1 : 4'd2;
    a = v[7:4];
    a = a > 4'd9 ? a - 4'd10 : a;
    return {o, a};
  endfunction

  task automatic do_reset();
    rst = 0; en = 0; man_ack = 0; auto_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_ins(input string name);
    int n = 0;
    while (tb_ins_o == 0 && n < 50) begin @(negedge clk); n++; end
    chk(name, 32'(tb_ins_o != 0), 1);
  endtask

  initial begin
    int base, n, nops, nwr, nrd;
    logic [15:0] m;
    logic stable;
    logic [3:0] op0, ad0;
    tbl[0] = '{4'd1, 4'd4}; tbl[1] = '{4'd0, 4'd7}; tbl[2] = '{4'd0, 4'd3};
    tbl[3] = '{4'd0, 4'd9}; tbl[4] = '{4'd2, 4'd4}; tbl[5] = '{4'd2, 4'd2};

    // reset held with enable high
    en = 1;
    repeat (3) @(negedge clk);
    chk("rst_ins", tb_ins_o, 0);
    chk("rst_addr", tb_ins_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_ins_cnt", ins_cnt_o, 0);
    chk("rst_wr_cnt", wr_cnt_o, 0);
    chk("rst_rd_cnt", rd_cnt_o, 0);
    chk("rst_lfsr", dut.lfsr, 16'hACE1);
    chk("rst_lfsr_zero_seed", dut2.lfsr, 16'h0001);

    // auto-ack run to completion
    auto_ack = 1;
    base = ev_q.size();
    rst = 1;
    n = 0;
    while (!done_o && n < 1000) begin @(negedge clk); n++; end
    chk("run_done", done_o, 1);
    chk("run_ins_cnt", ins_cnt_o, 20);
    chk("run_events", ev_q.size() - base, 20);
    nops = 0; nwr = 0; nrd = 0;
    m = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      if (ev_q[base+i][7:4] == 0) nops++;
      if (ev_q[base+i][7:4] == 1) nwr++;
      if (ev_q[base+i][7:4] == 2) nrd++;
      if (i < 6) chk($sformatf("tbl_%0d", i), ev_q[base+i], {tbl[i].op, tbl[i].addr});
      else chk($sformatf("model_%0d", i), ev_q[base+i], dec(m));
      chk($sformatf("addr_max_%0d", i), 32'(ev_q[base+i][3:0] <= 9), 1);
      m = step(m);
    end
    chk("run_wr_cnt", wr_cnt_o, nwr);
    chk("run_rd_cnt", rd_cnt_o, nrd);
    chk("run_sum", 32'(wr_cnt_o) + 32'(rd_cnt_o) + 32'(nops), 20);
    chk("run_nop_out", tb_ins_o, 0);
    chk("run_no_timeout", timeout_o, 0);
    repeat (3) @(negedge clk);
    chk("done_sticky", done_o, 1);
    chk("seed1_seen", got2, 1);
    chk("seed1_first", cap2, 8'h10);

    // stall: no ack for 600 cycles
    do_reset();
    en = 1;
    wait_ins("stall_issue");
    op0 = tb_ins_o; ad0 = tb_ins_addr_o;
    stable = 1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (tb_ins_o != op0 || tb_ins_addr_o != ad0) stable = 0;
      if (k == 499) chk("timeout_499", timeout_o, 0);
      if (k == 500) chk("timeout_500", timeout_o, 1);
    end
    chk("stall_stable", stable, 1);
    chk("stall_ins_cnt", ins_cnt_o, 0);
    man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    chk("stall_ack_cnt", ins_cnt_o, 1);
    chk("stall_ack_wr", wr_cnt_o, 1);
    chk("stall_ack_nop", tb_ins_o, 0);
    chk("timeout_sticky", timeout_o, 1);

    // enable dropped mid-ISSUE
    do_reset();
    en = 1;
    wait_ins("endrop_issue");
    en = 0;
    repeat (3) @(negedge clk);
    man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    repeat (6) @(negedge clk);
    chk("endrop_cnt", ins_cnt_o, 1);
    chk("endrop_wr", wr_cnt_o, 1);
    chk("endrop_nop", tb_ins_o, 0);
    chk("endrop_idle", 32'(int'(dut.state)), 0);
    base = ev_q.size();
    en = 1;
    n = 0;
    while (ev_q.size() < base + 2 && n < 50) begin @(negedge clk); n++; end
    chk("resume_events", ev_q.size() - base, 2);
    chk("resume_0", ev_q[base], 8'h07);
    chk("resume_1", ev_q[base+1], 8'h03);

    // reset pulse while a WR is pending
    do_reset();
    en = 1;
    wait_ins("rstmid_issue");
    rst = 0;
    @(negedge clk);
    chk("rstmid_ins", tb_ins_o, 0);
    chk("rstmid_cnt", ins_cnt_o, 0);
    chk("rstmid_wr", wr_cnt_o, 0);
    base = ev_q.size();
    rst = 1;
    n = 0;
    while (ev_q.size() == base && n < 50) begin @(negedge clk); n++; end
    chk("rstmid_first", ev_q[base], 8'h14);
    chk("rstmid_cnt_after", ins_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
